// File: rtl/i2c_event_queue_ctrl_if.sv
// rtl/i2c_event_queue_ctrl_if.sv - event/master handshake bundle for i2c_event_queue_ctrl
//
// Ports carried:
//   event side : ev_valid, ev_ready, ev_reg, ev_data, ev_mask, flush
//   master side: m_ready, m_done, m_start, m_mode, m_burst_len,
//                m_slave_addr, m_reg_addr, m_tx_data
//   status     : count, busy, drop
// Modport master is the sequencer's view; modport slave is the view of
// whatever sits around it (game FSMs plus the I2C master engine).
interface i2c_event_queue_ctrl_if #(
  parameter int N_SLAVES = 2,
  parameter int DEPTH    = 8
);
  logic                         ev_valid;
  logic                         ev_ready;
  logic [7:0]                   ev_reg;
  logic [N_SLAVES*8-1:0]        ev_data;
  logic [N_SLAVES-1:0]          ev_mask;
  logic                         flush;
  logic                         m_ready;
  logic                         m_done;
  logic                         m_start;
  logic [1:0]                   m_mode;
  logic [1:0]                   m_burst_len;
  logic [6:0]                   m_slave_addr;
  logic [7:0]                   m_reg_addr;
  logic [31:0]                  m_tx_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         busy;
  logic                         drop;

  modport master (
    input  ev_valid, ev_reg, ev_data, ev_mask, flush, m_ready, m_done,
    output ev_ready, m_start, m_mode, m_burst_len, m_slave_addr,
           m_reg_addr, m_tx_data, count, busy, drop
  );

  modport slave (
    output ev_valid, ev_reg, ev_data, ev_mask, flush, m_ready, m_done,
    input  ev_ready, m_start, m_mode, m_burst_len, m_slave_addr,
           m_reg_addr, m_tx_data, count, busy, drop
  );
endinterface

// File: rtl/i2c_event_queue_ctrl.sv
// rtl/i2c_event_queue_ctrl.sv - queued I2C register-write sequencer for game events
//
// Buffers {reg, per-slave data, slave mask} events in a FIFO and expands
// each one into single-byte register writes, one per selected slave in
// ascending slave order. A flush empties the FIFO and then zeroes reg 0x00
// and reg 0x01 of every slave.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - i2c_event_queue_ctrl_if.master (event push, master handshake, status)
module i2c_event_queue_ctrl #(
  parameter int                    N_SLAVES    = 2,
  parameter int                    DEPTH       = 8,
  parameter logic [N_SLAVES*7-1:0] SLAVE_ADDRS = {7'h2A, 7'h55}
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_event_queue_ctrl_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0] CLR_LAST = 5'(2 * N_SLAVES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, CLR_ISSUE, CLR_WAIT} state_t;
  state_t state, state_n;

  logic [7:0]            mem_reg  [DEPTH];
  logic [N_SLAVES*8-1:0] mem_data [DEPTH];
  logic [N_SLAVES-1:0]   mem_mask [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  // Working copy of the entry being fanned out.
  logic [7:0]            cur_reg;
  logic [N_SLAVES*8-1:0] cur_data;
  logic [N_SLAVES-1:0]   cur_mask;

  logic [3:0]  idx, idx_n, nx, first_set;
  logic [4:0]  clr_idx, clr_idx_n;
  logic        flush_pend, flush_pend_n;
  logic        clr_restart, clr_restart_n;
  logic        m_start, start_n;
  logic [6:0]  m_slave_addr;
  logic [7:0]  m_reg_addr;
  logic [31:0] m_tx_data;
  logic        drop;

  logic        ev_ready, push, pop, load, head_any;
  logic [3:0]  ld_slave;
  logic [7:0]  ld_reg, ld_byte;

  function automatic logic [6:0] slave_addr(input logic [3:0] s);
    return SLAVE_ADDRS[int'(s)*7 +: 7];
  endfunction

  function automatic logic [7:0] byte_of(input logic [N_SLAVES*8-1:0] d, input logic [3:0] s);
    return d[int'(s)*8 +: 8];
  endfunction

  assign ev_ready = (count < CNT_W'(DEPTH));
  // A flush cycle swallows any concurrent push; the event is reported via drop.
  assign push     = bus.ev_valid && ev_ready && !bus.flush;
  assign nx       = idx + 4'd1;

  // Lowest set mask bit of the FIFO head, used when popping in IDLE.
  always_comb begin
    first_set = '0;
    head_any  = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (mem_mask[rd_ptr][i]) begin
        first_set = 4'(i);
        head_any  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    clr_idx_n     = clr_idx;
    clr_restart_n = clr_restart;
    flush_pend_n  = flush_pend;
    start_n       = 1'b0;
    pop           = 1'b0;
    load          = 1'b0;
    ld_slave      = idx;
    ld_reg        = cur_reg;
    ld_byte       = 8'h00;

    if (bus.flush) flush_pend_n = 1'b1;

    case (state)
      IDLE: begin
        if (bus.flush) begin
          state_n   = CLR_ISSUE;
          clr_idx_n = '0;
        end else if (count != '0) begin
          pop   = 1'b1;
          idx_n = '0;
          // An all-zero mask is simply consumed; IDLE is held.
          if (head_any) begin
            idx_n    = first_set;
            load     = 1'b1;
            ld_slave = first_set;
            ld_reg   = mem_reg[rd_ptr];
            ld_byte  = byte_of(mem_data[rd_ptr], first_set);
            state_n  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.flush) begin
          state_n   = CLR_ISSUE;
          clr_idx_n = '0;
        end else if (bus.m_ready) begin
          start_n = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A flush seen here leaves flush_pend set; it redirects on m_done.
        if (bus.m_done) begin
          if (bus.flush || flush_pend) begin
            state_n   = CLR_ISSUE;
            clr_idx_n = '0;
          end else begin
            state_n = NEXT;
          end
        end
      end
      NEXT: begin
        if (bus.flush) begin
          state_n   = CLR_ISSUE;
          clr_idx_n = '0;
        end else if (nx >= 4'(N_SLAVES)) begin
          state_n = IDLE;
        end else begin
          idx_n = nx;
          if (cur_mask[nx]) begin
            load     = 1'b1;
            ld_slave = nx;
            ld_reg   = cur_reg;
            ld_byte  = byte_of(cur_data, nx);
            state_n  = ISSUE;
          end
        end
      end
      CLR_ISSUE: begin
        if (bus.flush) begin
          clr_idx_n = '0;
        end else if (bus.m_ready) begin
          // clr_idx walks slave-major: {slave, reg bit}.
          start_n  = 1'b1;
          load     = 1'b1;
          ld_slave = clr_idx[4:1];
          ld_reg   = {7'd0, clr_idx[0]};
          ld_byte  = 8'h00;
          state_n  = CLR_WAIT;
        end
      end
      CLR_WAIT: begin
        if (bus.flush) clr_restart_n = 1'b1;
        if (bus.m_done) begin
          if (bus.flush || clr_restart) begin
            clr_idx_n     = '0;
            clr_restart_n = 1'b0;
            state_n       = CLR_ISSUE;
          end else if (clr_idx == CLR_LAST) begin
            flush_pend_n = 1'b0;
            state_n      = IDLE;
          end else begin
            clr_idx_n = clr_idx + 5'd1;
            state_n   = CLR_ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      clr_idx      <= '0;
      flush_pend   <= 1'b0;
      clr_restart  <= 1'b0;
      m_start      <= 1'b0;
      m_slave_addr <= '0;
      m_reg_addr   <= '0;
      m_tx_data    <= '0;
      cur_reg      <= '0;
      cur_data     <= '0;
      cur_mask     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop         <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      clr_idx     <= clr_idx_n;
      flush_pend  <= flush_pend_n;
      clr_restart <= clr_restart_n;
      m_start     <= start_n;
      drop        <= bus.ev_valid && (!ev_ready || bus.flush);
      if (pop) begin
        cur_reg  <= mem_reg[rd_ptr];
        cur_data <= mem_data[rd_ptr];
        cur_mask <= mem_mask[rd_ptr];
      end
      if (load) begin
        m_slave_addr <= slave_addr(ld_slave);
        m_reg_addr   <= ld_reg;
        m_tx_data    <= {ld_byte, 24'd0};
      end
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= bus.ev_reg;
      mem_data[wr_ptr] <= bus.ev_data;
      mem_mask[wr_ptr] <= bus.ev_mask;
    end
  end

  assign bus.ev_ready     = ev_ready;
  assign bus.m_start      = m_start;
  assign bus.m_mode       = 2'b10;
  assign bus.m_burst_len  = 2'b00;
  assign bus.m_slave_addr = m_slave_addr;
  assign bus.m_reg_addr   = m_reg_addr;
  assign bus.m_tx_data    = m_tx_data;
  assign bus.count        = count;
  assign bus.busy         = (state != IDLE) || (count != '0) || flush_pend;
  assign bus.drop         = drop;
endmodule
